// File: rtl/alu_pkg.sv
// Opcode encodings, opcode classification helpers and response-buffer states
// shared by the ALU and the arbiter.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADCS = 4'b0001;
    localparam logic [3:0] OP_ANDS = 4'b0010;
    localparam logic [3:0] OP_ORRS = 4'b0011;
    localparam logic [3:0] OP_RSBS = 4'b0100;
    localparam logic [3:0] OP_SBCS = 4'b0101;
    localparam logic [3:0] OP_SUBS = 4'b0110;
    localparam logic [3:0] OP_CMP  = 4'b0111;
    localparam logic [3:0] OP_MULS = 4'b1000;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= OP_MULS;
    endfunction

    function automatic logic uses_cin(input logic [3:0] op);
        return (op == OP_ADCS) || (op == OP_SBCS);
    endfunction

    function automatic logic writes_carry(input logic [3:0] op);
        return (op == OP_ADD)  || (op == OP_ADCS) || (op == OP_RSBS) ||
               (op == OP_SBCS) || (op == OP_SUBS) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU. Subtractions use the not-borrow carry convention
// (a + ~b + 1); illegal opcodes yield err=1 with result and all flags zero.
module alu
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [3:0]   opcode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         nf,
    output logic         zf,
    output logic         err
);

    logic [W:0] sum;
    logic [W:0] one;
    logic [W:0] cin_ext;

    assign one     = {{W{1'b0}}, 1'b1};
    assign cin_ext = {{W{1'b0}}, cin};

    always_comb begin
        sum = '0;
        err = 1'b0;
        unique case (opcode)
            OP_ADD:          sum = {1'b0, a} + {1'b0, b};
            OP_ADCS:         sum = {1'b0, a} + {1'b0, b} + cin_ext;
            OP_ANDS:         sum = {1'b0, a & b};
            OP_ORRS:         sum = {1'b0, a | b};
            OP_RSBS:         sum = {1'b0, b} + {1'b0, ~a} + one;
            OP_SBCS:         sum = {1'b0, a} + {1'b0, ~b} + cin_ext;
            OP_SUBS, OP_CMP: sum = {1'b0, a} + {1'b0, ~b} + one;
            OP_MULS:         sum = {1'b0, a * b};
            default:         err = 1'b1;
        endcase
    end

    assign result = sum[W-1:0];
    assign cout   = sum[W];
    assign nf     = result[W-1];
    assign zf     = (result == '0) & ~err;

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: round-robin or fixed-priority
// grant, per-requester carry flag, single-entry registered response buffer.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_opcode,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_opcode,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_cout,
    output logic              rsp_nf,
    output logic              rsp_zf,
    output logic              rsp_err
);

    buf_state_t        state;
    logic              last_grant;
    logic [1:0]        c_flag;
    logic              grant;
    logic              can_accept;
    logic              accept;
    logic [3:0]        op_sel;
    logic [DATA_W-1:0] a_sel;
    logic [DATA_W-1:0] b_sel;
    logic              cin_sel;
    logic [DATA_W-1:0] alu_result;
    logic              alu_cout;
    logic              alu_nf;
    logic              alu_zf;
    logic              alu_err;

    always_comb begin
        if (req0_valid && req1_valid) grant = RR_EN ? ~last_grant : 1'b0;
        else                          grant = req1_valid;
    end

    // A draining consumer frees the buffer in the same edge, so issue never stalls on it.
    assign can_accept = (state == EMPTY) | rsp_ready;
    assign req0_ready = can_accept & req0_valid & ~grant;
    assign req1_ready = can_accept & req1_valid & grant;
    assign accept     = req0_ready | req1_ready;

    assign op_sel  = grant ? req1_opcode : req0_opcode;
    assign a_sel   = grant ? req1_a : req0_a;
    assign b_sel   = grant ? req1_b : req0_b;
    assign cin_sel = uses_cin(op_sel) & c_flag[grant];

    alu #(.W(DATA_W)) u_alu (
        .opcode (op_sel),
        .a      (a_sel),
        .b      (b_sel),
        .cin    (cin_sel),
        .result (alu_result),
        .cout   (alu_cout),
        .nf     (alu_nf),
        .zf     (alu_zf),
        .err    (alu_err)
    );

    assign rsp_valid = (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            last_grant <= 1'b1;
            c_flag     <= 2'b00;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            rsp_nf     <= 1'b0;
            rsp_zf     <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                state      <= FULL;
                last_grant <= grant;
                rsp_id     <= grant;
                rsp_result <= alu_result;
                rsp_cout   <= alu_cout;
                rsp_nf     <= alu_nf;
                rsp_zf     <= alu_zf;
                rsp_err    <= alu_err;
                if (writes_carry(op_sel)) c_flag[grant] <= alu_cout;
            end else if (rsp_ready) begin
                state <= EMPTY;
            end
        end
    end

endmodule
